srsw_raddr_mem: RTL and testbench

- Single-read, single-write synchronous RAM with a registered read address: the read port latches the address, and the array is read combinationally through that latched address.
- Default geometry is 4 words x 32 bits.
- Used as a reference memory primitive in emulation and halt-equivalence checks: the same block runs natively and under an emulation wrapper, and the outputs must match cycle for cycle.
- Effective read latency is 1 cycle. A write to the currently latched address is visible on rdata on the next cycle.

---
 rtl/srsw_pkg.sv | 11 +
 rtl/srsw_mem_array.sv | 44 ++++
 rtl/srsw_raddr_mem.sv | 69 ++++++
 tb/tb_srsw_raddr_mem.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/srsw_pkg.sv
// rtl/srsw_pkg.sv - shared defaults and types for the registered-read-address RAM
package srsw_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/srsw_mem_array.sv
// rtl/srsw_mem_array.sv - storage array with one write port, synchronous clear and async read mux
module srsw_mem_array
    import srsw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Clear has priority over the write so a reset cycle always leaves all words zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Read straight from the stored state: no path from wdata to rdata in the same cycle.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/srsw_raddr_mem.sv
// rtl/srsw_raddr_mem.sv - single-read single-write RAM with latched read address; optional halt via SRSW_RADDR_HALT_EN
module srsw_raddr_mem
    import srsw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SRSW_RADDR_HALT_EN
    input  logic                  halt,
`endif
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic                  run;
    logic                  clr;
    logic                  we;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH-1:0] raddr_d;

    // A halted edge must look exactly like a missing clock edge, reset included.
`ifdef SRSW_RADDR_HALT_EN
    assign run = ~halt;
`else
    assign run = 1'b1;
`endif

    assign clr = rst & run;
    assign we  = wen & run & ~rst;
    assign re  = ren & run & ~rst;

    always_comb begin
        raddr_d = raddr_q;
        if (re) begin
            raddr_d = raddr;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= raddr_d;
        end
    end

    srsw_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .clr   (clr),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_srsw_raddr_mem.sv
// tb/tb_srsw_raddr_mem.sv - self-checking bench for srsw_raddr_mem, halt scenarios under SRSW_RADDR_HALT_EN
module tb_srsw_raddr_mem;
    import srsw_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  halt = 1'b0;
    logic  wen = 1'b0;
    addr_t waddr = '0;
    data_t wdata = '0;
    logic  ren = 1'b0;
    addr_t raddr = '0;
    data_t rdata;

    int tests = 0;
    int fails = 0;

    data_t m_mem [4];
    addr_t m_ra;

    always #5 clk = ~clk;

    srsw_raddr_mem dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SRSW_RADDR_HALT_EN
        .halt  (halt),
`endif
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic cycle();
        @(posedge clk);
        if (!halt) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) m_mem[i] = '0;
                m_ra = '0;
            end else begin
                if (wen) m_mem[waddr] = wdata;
                if (ren) m_ra = raddr;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; wen = 0; ren = 0; halt = 0;
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < 4; i++) begin
            wen = 1; waddr = addr_t'(i); wdata = 32'hC0DE_0000 + i;
            cycle();
        end
        rst = 1; wen = 1; waddr = 0; wdata = 32'hFFFF_FFFF; ren = 1; raddr = 2;
        cycle();
        idle();
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            ren = 1; raddr = addr_t'(i);
            cycle();
            tests++;
            if (rdata !== 32'h0) begin
                fails++;
                $display("FAIL reset_read_addr%0d: got %h expected %h", i, rdata, 32'h0);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        idle();
        wen = 1; waddr = 2; wdata = 32'hDEAD_BEEF;
        cycle();
        idle();
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL write_read_before: got %h expected %h", rdata, 32'h0);
        end
        ren = 1; raddr = 2;
        cycle();
        idle();
        tests++;
        if (rdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL write_read: got %h expected %h", rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        wen = 1; waddr = 1; wdata = 32'h1234_5678; ren = 1; raddr = 1;
        #1;
        tests++;
        if (rdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL same_cycle_no_bypass: got %h expected %h", rdata, 32'hDEAD_BEEF);
        end
        cycle();
        idle();
        tests++;
        if (rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL same_cycle_write_first: got %h expected %h", rdata, 32'h1234_5678);
        end
    endtask

    task automatic test_write_latched();
        idle();
        wen = 1; waddr = 3; wdata = 32'hA5A5_A5A5; ren = 1; raddr = 3;
        cycle();
        idle();
        tests++;
        if (rdata !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL latched_initial: got %h expected %h", rdata, 32'hA5A5_A5A5);
        end
        wen = 1; waddr = 3; wdata = 32'h5A5A_5A5A; raddr = 0;
        cycle();
        idle();
        tests++;
        if (rdata !== 32'h5A5A_5A5A) begin
            fails++;
            $display("FAIL latched_write_no_ren: got %h expected %h", rdata, 32'h5A5A_5A5A);
        end
    endtask

    task automatic test_hold();
        idle();
        for (int i = 0; i < 3; i++) begin
            raddr = addr_t'(i);
            cycle();
            tests++;
            if (rdata !== 32'h5A5A_5A5A) begin
                fails++;
                $display("FAIL hold_raddr%0d: got %h expected %h", i, rdata, 32'h5A5A_5A5A);
            end
        end
    endtask

    task automatic test_random(input int n, input bit use_halt);
        data_t exp;
        for (int c = 0; c < n; c++) begin
            rst   = ($urandom_range(0, 31) == 0);
            wen   = $urandom_range(0, 1) == 1;
            waddr = addr_t'($urandom);
            wdata = data_t'($urandom);
            ren   = $urandom_range(0, 1) == 1;
            raddr = addr_t'($urandom);
            halt  = use_halt && ($urandom_range(0, 2) == 0);
            #1;
            exp = m_mem[m_ra];
            tests++;
            if (rdata !== exp) begin
                fails++;
                $display("FAIL random_pre_edge c=%0d: got %h expected %h", c, rdata, exp);
            end
            cycle();
            exp = m_mem[m_ra];
            tests++;
            if (rdata !== exp) begin
                fails++;
                $display("FAIL random_post_edge c=%0d: got %h expected %h", c, rdata, exp);
            end
        end
        idle();
    endtask

`ifdef SRSW_RADDR_HALT_EN
    task automatic test_halt_reset();
        idle();
        wen = 1; waddr = 2; wdata = 32'h0BAD_F00D; ren = 1; raddr = 2;
        cycle();
        idle();
        halt = 1; rst = 1; wen = 1; waddr = 2; wdata = 32'h1111_1111; ren = 1; raddr = 0;
        cycle();
        idle();
        tests++;
        if (rdata !== 32'h0BAD_F00D) begin
            fails++;
            $display("FAIL halt_blocks_reset: got %h expected %h", rdata, 32'h0BAD_F00D);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_write_latched();
        test_hold();
        test_random(300, 1'b0);
`ifdef SRSW_RADDR_HALT_EN
        test_halt_reset();
        test_random(500, 1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
